// File: rtl/control_decode_pipe.sv
// Registered RV32I control decoder between fetch and execute; stalls on branches/jumps and
// squashes wrong-path fetches. Define ILLEGAL_TRAP_EN to flag undecodable words via illegalInst.
module control_decode_pipe #(
    parameter int FLUSH_CYCLES = 2,
    parameter int ALU_OP_W     = 4,
    parameter int IMM_W        = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst,
    input  logic                br_resolve,
    input  logic                branchValid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                branchEn,
    output logic [2:0]          immExtCtrl,
    output logic [IMM_W-1:0]    imm_data,
    output logic [2:0]          branchCompareOp,
    output logic                aluS1Sel,
    output logic                aluS2Sel,
    output logic [ALU_OP_W-1:0] aluOp,
    output logic [4:0]          memControl,
    output logic                regWriteEn,
    output logic                regWriteBackDataSel,
    output logic                linkRegWriteEn,
    output logic                illegalInst
);
    // ALU operation codes shared with execute
    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] EXE_SUB_OP  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] EXE_SLT_OP  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = ALU_OP_W'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    localparam logic [3:0] FLUSH_LAST = 4'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);

    typedef struct packed {
        logic [2:0]          imm_ctrl;
        logic [IMM_W-1:0]    imm;
        logic [2:0]          cmp_op;
        logic                s1_sel;
        logic                s2_sel;
        logic [ALU_OP_W-1:0] alu_op;
        logic [4:0]          mem_ctrl;
        logic                reg_we;
        logic                wb_sel;
        logic                link_we;
        logic                illegal;
    } bundle_t;

    typedef enum logic [1:0] {RUN, WAIT_RES, FLUSH} state_t;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [11:0] imm_i, imm_s, imm_b;
    logic [19:0] imm_u;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = inst[31:20];
    assign imm_s  = {inst[31:25], inst[11:7]};
    assign imm_b  = {inst[31], inst[7], inst[30:25], inst[11:8]};
    assign imm_u  = inst[31:12];

    function automatic logic [ALU_OP_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? EXE_SUB_OP : EXE_ADD_OP;
            3'b001:  alu_sel = EXE_SLL_OP;
            3'b010:  alu_sel = EXE_SLT_OP;
            3'b011:  alu_sel = EXE_SLTU_OP;
            3'b100:  alu_sel = EXE_XOR_OP;
            3'b101:  alu_sel = alt ? EXE_SRA_OP : EXE_SRL_OP;
            3'b110:  alu_sel = EXE_OR_OP;
            default: alu_sel = EXE_AND_OP;
        endcase
    endfunction

    bundle_t dec, bundle_q;
    logic    dec_legal, dec_xfer, dec_jump;

    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        dec_xfer  = 1'b0;
        dec_jump  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_legal  = (funct7 == 7'h00) ||
                             (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec.alu_op = alu_sel(funct3, inst[30]);
                dec.s1_sel = 1'b1;
                dec.reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                // funct7 only matters for the shift-immediate forms
                if (funct3 == 3'b001)
                    dec_legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                dec.alu_op   = alu_sel(funct3, funct3 == 3'b101 && inst[30]);
                dec.imm_ctrl = IMM_I;
                dec.imm      = IMM_W'({8'h00, imm_i});
                dec.s1_sel   = 1'b1;
                dec.s2_sel   = 1'b1;
                dec.reg_we   = 1'b1;
            end
            OPC_LOAD: begin
                dec_legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec.imm_ctrl = IMM_I;
                dec.imm      = IMM_W'({8'h00, imm_i});
                dec.s1_sel   = 1'b1;
                dec.s2_sel   = 1'b1;
                dec.mem_ctrl = {2'b01, funct3};
                dec.reg_we   = 1'b1;
                dec.wb_sel   = 1'b1;
            end
            OPC_STORE: begin
                dec_legal    = (funct3[2] == 1'b0) && (funct3 != 3'b011);
                dec.imm_ctrl = IMM_S;
                dec.imm      = IMM_W'({8'h00, imm_s});
                dec.s1_sel   = 1'b1;
                dec.s2_sel   = 1'b1;
                dec.mem_ctrl = {2'b10, funct3};
            end
            OPC_BRANCH: begin
                dec_legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.imm_ctrl = IMM_B;
                dec.imm      = IMM_W'({8'h00, imm_b});
                dec.cmp_op   = funct3;
                dec.s2_sel   = 1'b1;
                dec_xfer     = 1'b1;
            end
            OPC_JAL: begin
                dec.imm_ctrl = IMM_J;
                dec.imm      = IMM_W'(imm_u);
                dec.s2_sel   = 1'b1;
                dec.reg_we   = 1'b1;
                dec.link_we  = 1'b1;
                dec_xfer     = 1'b1;
                dec_jump     = 1'b1;
            end
            OPC_JALR: begin
                dec_legal    = (funct3 == 3'b000);
                dec.imm_ctrl = IMM_I;
                dec.imm      = IMM_W'({8'h00, imm_i});
                dec.s1_sel   = 1'b1;
                dec.s2_sel   = 1'b1;
                dec.reg_we   = 1'b1;
                dec.link_we  = 1'b1;
                dec_xfer     = 1'b1;
                dec_jump     = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.imm_ctrl = IMM_U;
                dec.imm      = IMM_W'(imm_u);
                dec.s1_sel   = (opcode == OPC_LUI);
                dec.s2_sel   = 1'b1;
                dec.reg_we   = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        // An illegal word never stalls, even if its opcode is a control transfer
        if (!dec_legal) begin
            dec      = '0;
            dec_xfer = 1'b0;
            dec_jump = 1'b0;
`ifdef ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
`else
            dec.illegal = 1'b0;
`endif
        end
    end

    state_t     state, state_n;
    logic [3:0] flush_cnt, flush_cnt_n;
    logic       br_en_n, jump_q, accept, load;

    assign in_ready = (state == FLUSH) || (state == RUN && (!out_valid || out_ready));
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            branchEn  <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            branchEn  <= br_en_n;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        br_en_n     = 1'b0;
        case (state)
            RUN: if (load && dec_xfer) state_n = WAIT_RES;
            WAIT_RES: begin
                if (br_resolve) begin
                    if (jump_q || branchValid) begin
                        br_en_n     = 1'b1;
                        flush_cnt_n = '0;
                        state_n     = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            FLUSH: begin
                if (accept) begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state_n     = RUN;
                        flush_cnt_n = '0;
                    end else begin
                        flush_cnt_n = flush_cnt + 4'd1;
                    end
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
            jump_q    <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            bundle_q  <= dec;
            jump_q    <= dec_jump;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign immExtCtrl          = bundle_q.imm_ctrl;
    assign imm_data            = bundle_q.imm;
    assign branchCompareOp     = bundle_q.cmp_op;
    assign aluS1Sel            = bundle_q.s1_sel;
    assign aluS2Sel            = bundle_q.s2_sel;
    assign aluOp               = bundle_q.alu_op;
    assign memControl          = bundle_q.mem_ctrl;
    assign regWriteEn          = bundle_q.reg_we;
    assign regWriteBackDataSel = bundle_q.wb_sel;
    assign linkRegWriteEn      = bundle_q.link_we;
    assign illegalInst         = bundle_q.illegal;
endmodule
